// File: rtl/object_detector.sv
// Colour-blob detector over a raster pixel stream.
// Counts pixels matching a red-ish colour window in each frame, tracks the bounding box
// of those pixels and publishes the result once per frame with a one-cycle done pulse.
//
// Ports:
//   clk             - system clock, rising edge
//   rst_n           - asynchronous active-low reset
//   iPixel          - RGB888 pixel {R,G,B}, sampled when iPixelValid is high
//   iPixelValid     - pixel qualifier (iSOF/iEOL ignored when low)
//   iSOF            - first pixel of a frame
//   iEOL            - last pixel of a line
//   oObjectDetected - level, set when last frame had at least MIN_PIXELS matches
//   oFrameDone      - one-cycle pulse when a frame result is published
//   oPixelCount     - matching-pixel count of the last published frame
//   oXMin/oXMax     - bounding-box columns of the last published frame
//   oYMin/oYMax     - bounding-box rows of the last published frame
module object_detector #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned MIN_PIXELS = 64,
  parameter int unsigned R_MIN      = 160,
  parameter int unsigned G_MAX      = 80,
  parameter int unsigned B_MAX      = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] iPixel,
  input  logic        iPixelValid,
  input  logic        iSOF,
  input  logic        iEOL,
  output logic        oObjectDetected,
  output logic        oFrameDone,
  output logic [19:0] oPixelCount,
  output logic [10:0] oXMin,
  output logic [10:0] oXMax,
  output logic [9:0]  oYMin,
  output logic [9:0]  oYMax
);

  localparam logic [10:0] HActive   = 11'(H_ACTIVE);
  localparam logic [9:0]  VLast     = 10'(V_ACTIVE - 1);
  localparam logic [19:0] MinPixels = 20'(MIN_PIXELS);
  localparam logic [7:0]  RMin      = 8'(R_MIN);
  localparam logic [7:0]  GMax      = 8'(G_MAX);
  localparam logic [7:0]  BMax      = 8'(B_MAX);
  localparam logic [19:0] CntMax    = '1;

  typedef enum logic [1:0] {StIdle, StActive, StReport} state_e;

  state_e      state_q;
  logic [10:0] x_q, xmin_q, xmax_q;
  logic [9:0]  y_q, ymin_q, ymax_q;
  logic [19:0] cnt_q;

  logic        det_q, done_q;
  logic [19:0] pcnt_q;
  logic [10:0] oxmin_q, oxmax_q;
  logic [9:0]  oymin_q, oymax_q;

  logic        start, accept, match, hit, first, last_line;
  logic [10:0] x_b, xmin_b, xmax_b, x_d, xmin_d, xmax_d;
  logic [9:0]  y_b, ymin_b, ymax_b, y_d, ymin_d, ymax_d;
  logic [19:0] cnt_b, cnt_d;

  // A valid SOF restarts accumulation from any state; otherwise only ACTIVE takes pixels.
  assign start  = iPixelValid & iSOF;
  assign accept = start | (iPixelValid & (state_q == StActive));
  assign match  = (iPixel[23:16] >= RMin) & (iPixel[15:8] <= GMax) & (iPixel[7:0] <= BMax);

  always_comb begin
    // Base is the running frame state, or a clean slate when this pixel opens a frame.
    x_b    = start ? '0 : x_q;
    y_b    = start ? '0 : y_q;
    cnt_b  = start ? '0 : cnt_q;
    xmin_b = start ? '0 : xmin_q;
    xmax_b = start ? '0 : xmax_q;
    ymin_b = start ? '0 : ymin_q;
    ymax_b = start ? '0 : ymax_q;

    // Pixels past the active width (missing EOL) are not evaluated.
    hit       = match & (x_b < HActive);
    first     = (cnt_b == '0);
    last_line = (y_b == VLast);

    cnt_d  = (hit && cnt_b != CntMax) ? cnt_b + 20'd1 : cnt_b;
    xmin_d = (hit && (first || x_b < xmin_b)) ? x_b : xmin_b;
    xmax_d = (hit && (first || x_b > xmax_b)) ? x_b : xmax_b;
    ymin_d = (hit && (first || y_b < ymin_b)) ? y_b : ymin_b;
    ymax_d = (hit && (first || y_b > ymax_b)) ? y_b : ymax_b;

    // x parks at H_ACTIVE on overlong lines so it cannot wrap back into range.
    x_d = iEOL ? '0 : ((x_b < HActive) ? x_b + 11'd1 : x_b);
    y_d = iEOL ? y_b + 10'd1 : y_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      det_q   <= 1'b0;
      done_q  <= 1'b0;
      pcnt_q  <= '0;
      oxmin_q <= '0;
      oxmax_q <= '0;
      oymin_q <= '0;
      oymax_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        x_q    <= x_d;
        y_q    <= y_d;
        cnt_q  <= cnt_d;
        xmin_q <= xmin_d;
        xmax_q <= xmax_d;
        ymin_q <= ymin_d;
        ymax_q <= ymax_d;
        if (iEOL && last_line) begin
          // Publish on the same edge that enters REPORT so results line up with the pulse.
          state_q <= StReport;
          done_q  <= 1'b1;
          det_q   <= (cnt_d >= MinPixels);
          pcnt_q  <= cnt_d;
          oxmin_q <= (cnt_d != '0) ? xmin_d : '0;
          oxmax_q <= (cnt_d != '0) ? xmax_d : '0;
          oymin_q <= (cnt_d != '0) ? ymin_d : '0;
          oymax_q <= (cnt_d != '0) ? ymax_d : '0;
        end else begin
          state_q <= StActive;
        end
      end else if (state_q == StReport) begin
        state_q <= StIdle;
      end
    end
  end

  assign oObjectDetected = det_q;
  assign oFrameDone      = done_q;
  assign oPixelCount     = pcnt_q;
  assign oXMin           = oxmin_q;
  assign oXMax           = oxmax_q;
  assign oYMin           = oymin_q;
  assign oYMax           = oymax_q;

endmodule

// File: tb/tb_object_detector.sv
module tb_object_detector;

  localparam int H = 8;
  localparam int V = 4;
  localparam int MinPix = 3;

  logic        clk, rst_n;
  logic [23:0] iPixel;
  logic        iPixelValid, iSOF, iEOL;
  logic        oObjectDetected, oFrameDone;
  logic [19:0] oPixelCount;
  logic [10:0] oXMin, oXMax;
  logic [9:0]  oYMin, oYMax;

  object_detector #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .MIN_PIXELS(MinPix),
    .R_MIN     (160),
    .G_MAX     (80),
    .B_MAX     (80)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iPixel         (iPixel),
    .iPixelValid    (iPixelValid),
    .iSOF           (iSOF),
    .iEOL           (iEOL),
    .oObjectDetected(oObjectDetected),
    .oFrameDone     (oFrameDone),
    .oPixelCount    (oPixelCount),
    .oXMin          (oXMin),
    .oXMax          (oXMax),
    .oYMin          (oYMin),
    .oYMax          (oYMax)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
    int det;
  } res_t;

  typedef struct {
    logic [23:0] color;
    int          x;
    int          y;
    res_t        exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [23:0] imgs [0:1][0:H*V-1];
  res_t got_q[$];

  // Every published result is captured away from the clock edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && oFrameDone === 1'b1)
      got_q.push_back('{int'(oPixelCount), int'(oXMin), int'(oXMax), int'(oYMin), int'(oYMax),
                        int'(oObjectDetected)});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_res(input string name, input res_t e);
    res_t g;
    if (got_q.size() == 0) begin
      chk({name, " result present"}, 0, 1);
    end else begin
      g = got_q.pop_front();
      chk({name, " count"}, g.cnt, e.cnt);
      chk({name, " xmin"}, g.xmin, e.xmin);
      chk({name, " xmax"}, g.xmax, e.xmax);
      chk({name, " ymin"}, g.ymin, e.ymin);
      chk({name, " ymax"}, g.ymax, e.ymax);
      chk({name, " detected"}, g.det, e.det);
    end
  endtask

  // Reference: evaluate the whole stored image against the colour rule.
  function automatic res_t model(input int f);
    res_t r;
    logic [23:0] p;
    r = '{0, H, -1, V, -1, 0};
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        p = imgs[f][y*H+x];
        if (p[23:16] >= 8'd160 && p[15:8] <= 8'd80 && p[7:0] <= 8'd80) begin
          r.cnt++;
          if (x < r.xmin) r.xmin = x;
          if (x > r.xmax) r.xmax = x;
          if (y < r.ymin) r.ymin = y;
          if (y > r.ymax) r.ymax = y;
        end
      end
    end
    if (r.cnt == 0) r = '{0, 0, 0, 0, 0, 0};
    r.det = (r.cnt >= MinPix) ? 1 : 0;
    return r;
  endfunction

  task automatic drive(input logic [23:0] p, input logic v, input logic s, input logic e);
    iPixel = p;
    iPixelValid = v;
    iSOF = s;
    iEOL = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(24'($urandom), 1'b0, 1'($urandom), 1'($urandom));
  endtask

  // gap: 0 none, 1 an idle before every pixel, 2 random idles. extra: random overlong lines.
  task automatic send_lines(input int f, input int y0, input int y1, input bit sof_en,
                            input int gap, input bit extra);
    int ne;
    for (int y = y0; y <= y1; y++) begin
      ne = extra ? $urandom_range(0, 2) : 0;
      for (int x = 0; x < H; x++) begin
        if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) idle();
        drive(imgs[f][y*H+x], 1'b1, sof_en && x == 0 && y == 0, x == H-1 && ne == 0);
      end
      for (int e = 0; e < ne; e++) drive(24'hFF0000, 1'b1, 1'b0, e == ne-1);
    end
  endtask

  task automatic send_frame(input int f, input int gap, input bit extra, input bit tail);
    send_lines(f, 0, V-1, 1'b1, gap, extra);
    if (tail) begin
      iPixelValid = 1'b0;
      iSOF = 1'b0;
      iEOL = 1'b0;
      @(negedge clk);
      chk("done right after final EOL", int'(oFrameDone), 1);
      @(posedge clk);
      #1;
      chk("done lasts one cycle", int'(oFrameDone), 0);
    end
  endtask

  task automatic clear_img(input int f);
    for (int i = 0; i < H*V; i++) imgs[f][i] = 24'h000000;
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, " detected"}, int'(oObjectDetected), 0);
    chk({name, " done"}, int'(oFrameDone), 0);
    chk({name, " count"}, int'(oPixelCount), 0);
    chk({name, " box"}, int'({oXMin, oXMax, oYMin, oYMax}), 0);
  endtask

  vec_t vecs[7];
  res_t e0, e1;
  logic [23:0] c;

  initial begin
    vecs[0] = '{24'hA00000, 1, 1, '{1, 1, 1, 1, 1, 0}};
    vecs[1] = '{24'h9F0000, 2, 2, '{0, 0, 0, 0, 0, 0}};
    vecs[2] = '{24'hA05050, 7, 3, '{1, 7, 7, 3, 3, 0}};
    vecs[3] = '{24'hA05150, 0, 0, '{0, 0, 0, 0, 0, 0}};
    vecs[4] = '{24'hA05051, 3, 0, '{0, 0, 0, 0, 0, 0}};
    vecs[5] = '{24'hFFFFFF, 4, 2, '{0, 0, 0, 0, 0, 0}};
    vecs[6] = '{24'hFF0000, 0, 0, '{1, 0, 0, 0, 0, 0}};

    rst_n = 1'b0;
    iPixel = '0;
    iPixelValid = 1'b0;
    iSOF = 1'b0;
    iEOL = 1'b0;
    for (int i = 0; i < 5; i++) drive(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check_outputs_zero("in reset");
    iPixelValid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Pixels without an SOF must not start a frame.
    for (int i = 0; i < 2*H*V; i++)
      drive(24'hFF0000, 1'b1, 1'b0, (i % H) == H-1);
    repeat (3) idle();
    chk("no frame without SOF", got_q.size(), 0);

    foreach (vecs[i]) begin
      clear_img(0);
      imgs[0][vecs[i].y*H+vecs[i].x] = vecs[i].color;
      send_frame(0, 0, 1'b0, 1'b1);
      chk($sformatf("vec%0d pulses", i), got_q.size(), 1);
      check_res($sformatf("vec%0d", i), vecs[i].exp);
    end

    // 2x2 red block.
    clear_img(0);
    imgs[0][1*H+2] = 24'hFF0000;
    imgs[0][1*H+3] = 24'hFF0000;
    imgs[0][2*H+2] = 24'hFF0000;
    imgs[0][2*H+3] = 24'hFF0000;
    send_frame(0, 0, 1'b0, 1'b1);
    chk("block pulses", got_q.size(), 1);
    check_res("block", '{4, 2, 3, 1, 2, 1});

    // Two corner pixels, below the detection threshold.
    clear_img(0);
    imgs[0][3*H+7] = 24'hFF0000;
    imgs[0][0] = 24'hFF0000;
    send_frame(0, 0, 1'b0, 1'b1);
    chk("corners pulses", got_q.size(), 1);
    check_res("corners", '{2, 0, 7, 0, 3, 0});
    repeat (4) idle();
    chk("held count", int'(oPixelCount), 2);
    chk("held xmax", int'(oXMax), 7);

    // All black with a gap before every pixel.
    clear_img(0);
    send_frame(0, 1, 1'b0, 1'b1);
    chk("black pulses", got_q.size(), 1);
    check_res("black", '{0, 0, 0, 0, 0, 0});

    // Reset in the middle of a frame that would otherwise be detected.
    for (int i = 0; i < H*V; i++) imgs[0][i] = 24'hFF0000;
    send_lines(0, 0, 1, 1'b1, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async reset");
    for (int i = 0; i < 3; i++) drive(24'($urandom), 1'b1, 1'($urandom), 1'($urandom));
    iPixelValid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_lines(0, 2, 3, 1'b0, 0, 1'b0);
    repeat (3) idle();
    chk("partial frame discarded", got_q.size(), 0);
    check_outputs_zero("after reset");

    // SOF on line 2 abandons a frame holding three matches.
    clear_img(0);
    imgs[0][1] = 24'hFF0000;
    imgs[0][2] = 24'hFF0000;
    imgs[0][H+1] = 24'hFF0000;
    send_lines(0, 0, 1, 1'b1, 0, 1'b0);
    chk("no done for aborted frame", int'(oFrameDone), 0);
    clear_img(1);
    send_frame(1, 0, 1'b0, 1'b1);
    chk("abort pulses", got_q.size(), 1);
    check_res("restarted", '{0, 0, 0, 0, 0, 0});

    // Back-to-back: next frame's SOF pixel lands in the REPORT cycle.
    clear_img(0);
    imgs[0][1*H+2] = 24'hFF0000;
    imgs[0][1*H+3] = 24'hFF0000;
    imgs[0][2*H+2] = 24'hFF0000;
    imgs[0][2*H+3] = 24'hFF0000;
    clear_img(1);
    imgs[1][0] = 24'hFF0000;
    imgs[1][H-1] = 24'hFF0000;
    imgs[1][3*H] = 24'hFF0000;
    imgs[1][3*H+7] = 24'hFF0000;
    send_frame(0, 0, 1'b0, 1'b0);
    send_frame(1, 0, 1'b0, 1'b1);
    chk("b2b pulses", got_q.size(), 2);
    check_res("b2b first", '{4, 2, 3, 1, 2, 1});
    check_res("b2b second", '{4, 0, 7, 0, 3, 1});

    // Random frames with gaps and overlong lines against the image model.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < H*V; i++) begin
        case ($urandom_range(0, 9))
          0, 1: c = {8'($urandom_range(160, 255)), 8'($urandom_range(0, 80)),
                     8'($urandom_range(0, 80))};
          2: c = {8'($urandom_range(150, 170)), 8'($urandom_range(70, 90)),
                  8'($urandom_range(70, 90))};
          3: c = 24'($urandom);
          default: c = 24'h000000;
        endcase
        imgs[0][i] = c;
      end
      e0 = model(0);
      send_frame(0, 2, 1'($urandom_range(0, 1)), 1'b1);
      chk($sformatf("rand%0d pulses", n), got_q.size(), 1);
      check_res($sformatf("rand%0d", n), e0);
      e1 = e0;
      repeat ($urandom_range(0, 3)) idle();
      chk($sformatf("rand%0d held", n), int'(oPixelCount), e1.cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
